// File: rtl/usr_pkg.sv
// usr_pkg: shared types for the usr_burst universal shift register.
//
// Contents:
//   usr_mode_e     3-bit operation select (HOLD, SHR, SHL, LOAD, ROR, ROL, ASR, CLEAR)
//   usr_state_e    burst engine state (IDLE, BUSY)
//   is_shift_mode  true for the modes a burst is allowed to repeat
package usr_pkg;

    typedef enum logic [2:0] {
        USR_HOLD  = 3'd0,
        USR_SHR   = 3'd1,
        USR_SHL   = 3'd2,
        USR_LOAD  = 3'd3,
        USR_ROR   = 3'd4,
        USR_ROL   = 3'd5,
        USR_ASR   = 3'd6,
        USR_CLEAR = 3'd7
    } usr_mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } usr_state_e;

    // HOLD, LOAD and CLEAR give the same result however often they repeat,
    // so only the moving modes can start a burst.
    function automatic logic is_shift_mode(input usr_mode_e m);
        return (m == USR_SHR) || (m == USR_SHL) || (m == USR_ROR) ||
               (m == USR_ROL) || (m == USR_ASR);
    endfunction

endpackage

// File: rtl/usr_step.sv
// usr_step: one step of the universal shift register, purely combinational.
// The same instance serves single-step cycles and every burst step.
//
// Ports:
//   cur       current register value
//   mode      operation to apply
//   right_in  fill bit entering the MSB on SHR
//   left_in   fill bit entering the LSB on SHL
//   par_in    parallel load value for LOAD
//   nxt       register value after the step
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur,
    input  usr_mode_e        mode,
    input  logic             right_in,
    input  logic             left_in,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] nxt
);

    always_comb begin
        nxt = cur;
        case (mode)
            USR_HOLD:  nxt = cur;
            USR_SHR:   nxt = {right_in, cur[WIDTH-1:1]};
            USR_SHL:   nxt = {cur[WIDTH-2:0], left_in};
            USR_LOAD:  nxt = par_in;
            USR_ROR:   nxt = {cur[0], cur[WIDTH-1:1]};
            USR_ROL:   nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
            USR_ASR:   nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
            USR_CLEAR: nxt = '0;
            default:   nxt = cur;
        endcase
    end

endmodule

// File: rtl/usr_burst.sv
// usr_burst: parametrised universal shift register with a multi-step burst
// engine. A single step is applied under en; a start with a shifting mode
// repeats that mode count times, with busy high meanwhile and a one-cycle
// done pulse at the end.
//
// Optional feature (macro USR_ABORT_EN): adds abort input and aborted output;
// abort while busy ends the burst at the next edge without stepping.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           single-step enable (idle only)
//   mode         operation select, see usr_mode_e
//   right_in     SHR fill bit, left_in SHL fill bit
//   par_in       parallel load data
//   start,count  burst request and number of steps (sampled when idle)
//   abort        (USR_ABORT_EN) cancel a running burst
//   out          register contents
//   ser_out_r    out[0], ser_out_l out[WIDTH-1]
//   busy         burst running, done one-cycle completion pulse
//   aborted      (USR_ABORT_EN) one-cycle pulse after an abort
module usr_burst
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             right_in,
    input  logic             left_in,
    input  logic [WIDTH-1:0] par_in,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
`ifdef USR_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic [WIDTH-1:0] out,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic             busy,
    output logic             done
);

    usr_state_e       state_q, state_d;
    usr_mode_e        burst_mode_q, burst_mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] out_d;
    logic             done_d;
    usr_mode_e        mode_in;
    usr_mode_e        step_mode;
    logic [WIDTH-1:0] step_val;
`ifdef USR_ABORT_EN
    logic             aborted_d;
`endif

    assign mode_in = usr_mode_e'(mode);

    // While a burst runs the latched mode drives the step; live mode is ignored.
    assign step_mode = (state_q == BUSY) ? burst_mode_q : mode_in;

    usr_step #(.WIDTH(WIDTH)) u_step (
        .cur      (out),
        .mode     (step_mode),
        .right_in (right_in),
        .left_in  (left_in),
        .par_in   (par_in),
        .nxt      (step_val)
    );

    assign ser_out_r = out[0];
    assign ser_out_l = out[WIDTH-1];
    assign busy      = (state_q == BUSY);

    // Next-state logic. A valid start (shifting mode) takes priority over en
    // even when count is zero, which only produces the done pulse. cnt holds
    // the number of steps still to perform.
    always_comb begin
        state_d      = state_q;
        burst_mode_d = burst_mode_q;
        cnt_d        = cnt_q;
        out_d        = out;
        done_d       = 1'b0;
`ifdef USR_ABORT_EN
        aborted_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start && is_shift_mode(mode_in)) begin
                    if (count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d      = BUSY;
                        burst_mode_d = mode_in;
                        cnt_d        = count;
                    end
                end else if (en) begin
                    out_d = step_val;
                end
            end
            BUSY: begin
`ifdef USR_ABORT_EN
                if (abort) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    aborted_d = 1'b1;
                end else begin
`else
                begin
`endif
                    out_d = step_val;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and data registers; reset clears everything at once,
    // cutting short any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            burst_mode_q <= USR_HOLD;
            cnt_q        <= '0;
            out          <= '0;
            done         <= 1'b0;
`ifdef USR_ABORT_EN
            aborted      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            burst_mode_q <= burst_mode_d;
            cnt_q        <= cnt_d;
            out          <= out_d;
            done         <= done_d;
`ifdef USR_ABORT_EN
            aborted      <= aborted_d;
`endif
        end
    end

endmodule

// File: tb/tb_usr_burst.sv
// tb_usr_burst: self-checking bench for usr_burst (WIDTH=8).
// The driver applies one input set per cycle, advances a behavioural model
// and queues the expected post-edge outputs; a monitor pops and compares
// one entry shortly after every rising edge. Directed steps add fixed
// expected values on top of the scoreboard.
module tb_usr_burst;

    localparam int W     = 8;
    localparam int CNT_W = 4;
`ifdef USR_ABORT_EN
    localparam bit HAS_ABORT = 1'b1;
`else
    localparam bit HAS_ABORT = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] out;
        logic         busy;
        logic         done;
        logic         aborted;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en_s, rin_s, lin_s, start_s, abort_s;
    logic [2:0]       mode_s;
    logic [W-1:0]     par_s;
    logic [CNT_W-1:0] count_s;
    logic [W-1:0]     dut_out;
    logic             ser_r, ser_l, dut_busy, dut_done;
    logic             dut_aborted;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    // Model state: register value, steps left in the burst, burst mode.
    logic [W-1:0] m_out;
    int           m_rem;
    logic [2:0]   m_mode;

    always #5 clk = ~clk;

    usr_burst #(.WIDTH(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en_s),
        .mode      (mode_s),
        .right_in  (rin_s),
        .left_in   (lin_s),
        .par_in    (par_s),
        .start     (start_s),
        .count     (count_s),
`ifdef USR_ABORT_EN
        .abort     (abort_s),
        .aborted   (dut_aborted),
`endif
        .out       (dut_out),
        .ser_out_r (ser_r),
        .ser_out_l (ser_l),
        .busy      (dut_busy),
        .done      (dut_done)
    );

`ifndef USR_ABORT_EN
    assign dut_aborted = 1'b0;
`endif

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference step written as plain arithmetic on the register value.
    function automatic logic [W-1:0] refStep(input logic [W-1:0] o, input logic [2:0] m,
                                             input logic r, input logic l, input logic [W-1:0] p);
        logic [W-1:0] msb;
        logic [W-1:0] lsb;
        msb = {1'b1, {(W-1){1'b0}}};
        lsb = {{(W-1){1'b0}}, 1'b1};
        case (m)
            3'd1:    return (o >> 1) | (r ? msb : '0);
            3'd2:    return (o << 1) | (l ? lsb : '0);
            3'd3:    return p;
            3'd4:    return (o >> 1) | (o[0] ? msb : '0);
            3'd5:    return (o << 1) | (o >> (W-1));
            3'd6:    return (o >> 1) | (o & msb);
            3'd7:    return '0;
            default: return o;
        endcase
    endfunction

    // Drive one cycle of inputs, advance the model across the coming edge
    // and queue what the outputs must show after it.
    task automatic applyStimulus(input logic e, input logic [2:0] m, input logic r, input logic l,
                                 input logic [W-1:0] p, input logic s, input logic [CNT_W-1:0] c,
                                 input logic a);
        logic nd, na;
        exp_t item;
        @(negedge clk);
        en_s = e; mode_s = m; rin_s = r; lin_s = l; par_s = p;
        start_s = s; count_s = c; abort_s = a;
        nd = 1'b0;
        na = 1'b0;
        if (m_rem > 0) begin
            if (a) begin
                m_rem = 0;
                na    = 1'b1;
            end else begin
                m_out = refStep(m_out, m_mode, r, l, p);
                m_rem = m_rem - 1;
                if (m_rem == 0) nd = 1'b1;
            end
        end else if (s && (m == 3'd1 || m == 3'd2 || m == 3'd4 || m == 3'd5 || m == 3'd6)) begin
            if (c == 0) nd = 1'b1;
            else begin
                m_mode = m;
                m_rem  = int'(c);
            end
        end else if (e) begin
            m_out = refStep(m_out, m, r, l, p);
        end
        item.out     = m_out;
        item.busy    = (m_rem > 0);
        item.done    = nd;
        item.aborted = na;
        sb_q.push_back(item);
    endtask

    task automatic holdCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic checkAfterEdge(input string name, input logic [W-1:0] exp_out,
                                  input logic exp_busy, input logic exp_done);
        @(posedge clk);
        #2;
        checkOutput({name, "_out"},  32'(dut_out),  32'(exp_out));
        checkOutput({name, "_busy"}, 32'(dut_busy), 32'(exp_busy));
        checkOutput({name, "_done"}, 32'(dut_done), 32'(exp_done));
    endtask

    // Monitor: one queued expectation per rising edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            checkOutput("sb_out",   32'(dut_out),  32'(mon_e.out));
            checkOutput("sb_busy",  32'(dut_busy), 32'(mon_e.busy));
            checkOutput("sb_done",  32'(dut_done), 32'(mon_e.done));
            checkOutput("sb_ser_r", 32'(ser_r),    32'(mon_e.out[0]));
            checkOutput("sb_ser_l", 32'(ser_l),    32'(mon_e.out[W-1]));
            if (HAS_ABORT) checkOutput("sb_aborted", 32'(dut_aborted), 32'(mon_e.aborted));
        end
    end

    initial begin
        rst_n = 1'b0;
        en_s = 0; mode_s = 0; rin_s = 0; lin_s = 0; par_s = 0;
        start_s = 0; count_s = 0; abort_s = 0;
        m_out = '0; m_rem = 0; m_mode = 3'd0;

        #3;
        checkOutput("reset_out",  32'(dut_out),  32'h0);
        checkOutput("reset_busy", 32'(dut_busy), 32'h0);
        checkOutput("reset_done", 32'(dut_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a 5-step burst
        applyStimulus(1'b1, 3'd3, 1'b0, 1'b0, 8'h5A, 1'b0, 4'd0, 1'b0);
        applyStimulus(1'b0, 3'd2, 1'b0, 1'b1, 8'h00, 1'b1, 4'd5, 1'b0);
        holdCycles(2);
        @(posedge clk);
        #3;
        checkOutput("pre_rst_busy", 32'(dut_busy), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out",  32'(dut_out),  32'h0);
        checkOutput("midrst_busy", 32'(dut_busy), 32'h0);
        m_out = '0; m_rem = 0; m_mode = 3'd0;
        @(negedge clk);
        rst_n = 1'b1;
        holdCycles(1);
        checkAfterEdge("post_rst_hold", 8'h00, 1'b0, 1'b0);

        // Single steps
        applyStimulus(1'b1, 3'd3, 1'b0, 1'b0, 8'hA5, 1'b0, 4'd0, 1'b0);
        checkAfterEdge("load_a5", 8'hA5, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd1, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0);
        checkAfterEdge("shr", 8'hD2, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd2, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0);
        checkAfterEdge("shl", 8'hA4, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd3, 1'b0, 1'b0, 8'h90, 1'b0, 4'd0, 1'b0);
        applyStimulus(1'b1, 3'd6, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0);
        checkAfterEdge("asr", 8'hC8, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd3, 1'b0, 1'b0, 8'h01, 1'b0, 4'd0, 1'b0);
        applyStimulus(1'b1, 3'd4, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0);
        checkAfterEdge("ror", 8'h80, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd7, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0);
        checkAfterEdge("clear", 8'h00, 1'b0, 1'b0);

        // Burst ROL x3 (en also high at start: start must win), back-to-back restart
        applyStimulus(1'b1, 3'd3, 1'b0, 1'b0, 8'h81, 1'b0, 4'd0, 1'b0);
        applyStimulus(1'b1, 3'd5, 1'b0, 1'b0, 8'h00, 1'b1, 4'd3, 1'b0);
        checkAfterEdge("rol_e0", 8'h81, 1'b1, 1'b0);
        holdCycles(1);
        checkAfterEdge("rol_e1", 8'h03, 1'b1, 1'b0);
        holdCycles(1);
        checkAfterEdge("rol_e2", 8'h06, 1'b1, 1'b0);
        holdCycles(1);
        checkAfterEdge("rol_e3", 8'h0C, 1'b0, 1'b1);
        applyStimulus(1'b0, 3'd5, 1'b0, 1'b0, 8'h00, 1'b1, 4'd2, 1'b0);
        checkAfterEdge("rol_restart", 8'h0C, 1'b1, 1'b0);
        holdCycles(2);

        // count=0 start: done pulse only
        applyStimulus(1'b1, 3'd2, 1'b0, 1'b1, 8'h00, 1'b1, 4'd0, 1'b0);
        checkAfterEdge("cnt0", 8'h30, 1'b0, 1'b1);
        holdCycles(1);

        // Inputs ignored during a burst of 4
        applyStimulus(1'b1, 3'd3, 1'b0, 1'b0, 8'h3C, 1'b0, 4'd0, 1'b0);
        applyStimulus(1'b0, 3'd1, 1'b0, 1'b0, 8'h00, 1'b1, 4'd4, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'd3, 1'b0, 1'b0, 8'hFF, 1'b1, 4'd7, 1'b0);
        holdCycles(1);
        checkAfterEdge("ignore_end", 8'h03, 1'b0, 1'b1);

`ifdef USR_ABORT_EN
        // Abort a SHL x6 burst after two steps
        applyStimulus(1'b1, 3'd3, 1'b0, 1'b0, 8'hFF, 1'b0, 4'd0, 1'b0);
        applyStimulus(1'b0, 3'd2, 1'b0, 1'b0, 8'h00, 1'b1, 4'd6, 1'b0);
        holdCycles(2);
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1);
        checkAfterEdge("abort", 8'hFC, 1'b0, 1'b0);
        checkOutput("abort_pulse", 32'(dut_aborted), 32'h1);
        holdCycles(2);
`endif

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            logic s, a;
            s = ($urandom_range(0, 5) == 0);
            a = HAS_ABORT && ($urandom_range(0, 9) == 0);
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 255)), s,
                          4'($urandom_range(0, 10)), a);
        end

        holdCycles(12);
        @(posedge clk);
        #3;
        checkOutput("sb_drain", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
